seq_mul64: RTL

Sequential 64×64→128-bit unsigned shift-add multiplier that time-shares one external 64-bit carry look-ahead adder. It sits directly upstream of the adder: each cycle it drives the adder operands and consumes the sum and carry-out in the same cycle. Operands are accepted with a start/busy/done handshake, and the product is held until the next accepted start.

---
 rtl/seq_mul64.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seq_mul64.sv
// seq_mul64: sequential 64x64->128 unsigned shift-add multiplier that
// time-shares an external 64-bit adder (one add/shift step per cycle).
// Optional feature macro: SEQ_MUL_EARLY_EXIT_EN. When it is defined, the
// multiply finishes as soon as the remaining multiplier bits are all zero,
// and a barrel shift applies the skipped shifts in one cycle.
module seq_mul64 #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   product,
  output logic [DATA_WIDTH-1:0]     add_lhs,
  output logic [DATA_WIDTH-1:0]     add_rhs,
  output logic                      add_cin,
  output logic                      add_inv,
  input  logic [DATA_WIDTH-1:0]     add_res,
  input  logic                      add_cout
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned STEP_W = PROD_W + 1;
  localparam int unsigned CNT_W  = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH-1:0]   acc_hi;
  logic [DATA_WIDTH-1:0]   acc_lo;
  logic [DATA_WIDTH-1:0]   mplr;
  logic [CNT_W-1:0]        cnt;

  logic [STEP_W-1:0]       step_wide;
  logic [PROD_W-1:0]       step_next;
  logic [DATA_WIDTH-1:0]   mplr_next;
  logic                    last_step;
  logic [PROD_W-1:0]       done_prod;

  // Carry, sum and the untouched low half form one wide word; a step is its right shift by one.
  assign step_wide = {add_cout, add_res, acc_lo};
  assign step_next = step_wide[STEP_W-1:1];
  assign mplr_next = mplr >> 1;
  assign last_step = (cnt == CNT_W'(DATA_WIDTH - 1));

  assign add_cin = 1'b0;
  assign add_inv = 1'b0;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  logic [CNT_W-1:0] shamt;
  logic             mplr_zero;

  // Skipped shifts plus the current one: 64 - cnt, always in 1..64.
  assign shamt     = CNT_W'(DATA_WIDTH) - cnt;
  assign mplr_zero = (mplr_next == '0);
  assign done_prod = PROD_W'(step_wide >> shamt);
`else
  logic unused_mplr;

  assign unused_mplr = mplr[0];
  assign done_prod   = step_next;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and adder operand drive (operands are zero outside RUN).
  always_comb begin
    state_next = state;
    add_lhs    = '0;
    add_rhs    = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
`ifdef SEQ_MUL_EARLY_EXIT_EN
          if (b == '0) begin
            state_next = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        add_lhs = acc_hi;
        add_rhs = acc_lo[0] ? mcand : '0;
`ifdef SEQ_MUL_EARLY_EXIT_EN
        if (last_step || mplr_zero) begin
          state_next = S_DONE;
        end
`else
        if (last_step) begin
          state_next = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers, handshake flags and the held product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mplr    <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_next != S_IDLE);
      done <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a;
            acc_lo <= b;
            mplr   <= b;
            acc_hi <= '0;
            cnt    <= '0;
`ifdef SEQ_MUL_EARLY_EXIT_EN
            if (b == '0) begin
              product <= '0;
            end
`endif
          end
        end
        S_RUN: begin
          {acc_hi, acc_lo} <= step_next;
          mplr             <= mplr_next;
          cnt              <= cnt + CNT_W'(1);
          if (state_next == S_DONE) begin
            product <= done_prod;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
